// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: deserialises 7 strobe-qualified bits MSB first, corrects single-bit errors.
// Optional corrected-error counter output err_count is enabled by defining HAMMING_RX_ERRCNT_EN.
module hamming_serial_rx #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             strobe_in,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic             err_corrected,
  output logic [2:0]       syndrome,
`ifdef HAMMING_RX_ERRCNT_EN
  output logic [CNT_W-1:0] err_count,
`endif
  output logic             frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("hamming_serial_rx: TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              strobe_q;
  logic              rise;
  logic [6:0]        code;
  logic [2:0]        bitcnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;
  logic              capture;
  logic              decode;
  logic              abort;
  logic [2:0]        syn;
  logic [6:0]        flip;
  logic [6:0]        fixed;

  assign rise        = strobe_in & ~strobe_q;
  assign timeout_hit = (state == RECV) && !rise && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the block leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rise) state_next = RECV;
      RECV: begin
        if (rise && bitcnt == 3'd6) state_next = DONE;
        else if (timeout_hit)       state_next = IDLE;
      end
      DONE: state_next = rise ? RECV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture = rise;
    decode  = (state == DONE);
    abort   = timeout_hit;
  end

  // A rise during DONE starts the next frame while the current codeword is still decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      code     <= '0;
      bitcnt   <= '0;
      idle_cnt <= '0;
    end else begin
      strobe_q <= strobe_in;
      if (capture) begin
        code   <= {code[5:0], d_in};
        bitcnt <= (state == RECV) ? bitcnt + 3'd1 : 3'd1;
      end else if (abort || decode) begin
        bitcnt <= '0;
      end
      if (state == RECV && !rise && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
      else                                        idle_cnt <= '0;
    end
  end

  always_comb begin
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    for (int i = 0; i < 7; i++) flip[i] = (syn == 3'(i + 1));
    fixed = code ^ flip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out      <= '0;
      syndrome      <= '0;
      data_valid    <= 1'b0;
      err_corrected <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      data_valid    <= decode;
      err_corrected <= decode && (syn != 3'd0);
      frame_err     <= abort;
      if (decode) begin
        data_out <= {fixed[6], fixed[5], fixed[4], fixed[2]};
        syndrome <= syn;
      end
    end
  end

`ifdef HAMMING_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              err_count <= '0;
    else if (decode && syn != 3'd0 && err_count != '1)    err_count <= err_count + 1'b1;
  end
`endif

endmodule
